// File: rtl/imem_load_ctrl.sv
// Boot-load controller that owns the mini-MIPS instruction store: the host streams
// words in while the core stalls, then the core fetches from it until it halts.
module imem_load_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [31:0]   cpu_instr,
  input  logic          cpu_halt,
  output logic          cpu_run,
  output logic          ld_err,
  output logic [AW:0]   ld_count
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] tgt_q, tgt_d;
  logic        err_q, err_d;
  logic        we;
  logic [31:0] mem [DEPTH];

  // The write pointer and ld_count always move together, so one register serves both.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          cnt_d   = '0;
          err_d   = (ld_len > DEPTH_L);
          tgt_d   = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
          state_d = (ld_len == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + (AW+1)'(1);
          if (cnt_d == tgt_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_halt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  // Store is never cleared; a reset on the same edge as a handshake suppresses the write.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[cnt_q[IW-1:0]] <= ld_data;
  end

  assign ld_ready  = (state_q == S_LOAD);
  assign cpu_run   = (state_q == S_RUN);
  assign ld_err    = err_q;
  assign ld_count  = cnt_q;
  assign cpu_instr = (cpu_run && ({1'b0, cpu_addr} < DEPTH_L)) ? mem[cpu_addr[IW-1:0]] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed scenarios plus a random phase, all against a
// behavioural model of the loader and its memory.
module tb_imem_load_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 15;

  logic          clk = 0;
  logic          rst = 1;
  logic          ld_start = 0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_instr;
  logic          cpu_halt = 0;
  logic          cpu_run;
  logic          ld_err;
  logic [AW:0]   ld_count;

  int total = 0;
  int bad   = 0;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_halt(cpu_halt),
    .cpu_run(cpu_run), .ld_err(ld_err), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = idle, 1 = loading, 2 = running
  int          m_mode = 0;
  int          m_ptr  = 0;
  int          m_tgt  = 0;
  bit          m_err  = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_err = 0;
    end else begin
      case (m_mode)
        0: if (ld_start) begin
             m_ptr  = 0;
             m_err  = (int'(ld_len) > DEPTH);
             m_tgt  = m_err ? DEPTH : int'(ld_len);
             m_mode = (ld_len == 0) ? 2 : 1;
           end
        1: if (ld_valid) begin
             m_mem[m_ptr] = ld_data;
             m_wr[m_ptr]  = 1;
             m_ptr++;
             if (m_ptr == m_tgt) m_mode = 2;
           end
        default: if (cpu_halt) m_mode = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic bit exp_known();
    return !(m_mode == 2 && int'(cpu_addr) < DEPTH && !m_wr[int'(cpu_addr)]);
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_mode == 2 && int'(cpu_addr) < DEPTH) return m_mem[int'(cpu_addr)];
    return 32'h0;
  endfunction

  task automatic test_reset();
    rst = 1; cycle(); cycle(); rst = 0; #1;
    total++; if (cpu_run !== 1'b0)  begin bad++; $display("FAIL reset_run got=%b exp=0", cpu_run); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
    total++; if (ld_err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", ld_err); end
    total++; if (ld_count !== '0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", ld_count); end
    total++; if (cpu_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", cpu_instr); end
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    int rdy = 0;
    w[0] = 32'h0400_0001; w[1] = 32'h4081_0012; w[2] = 32'h0822_0001;
    ld_start = 1; ld_len = 3; cycle(); ld_start = 0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = w[i];
      if (ld_ready) rdy++;
      total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL basic_early_run i=%0d got=%b exp=0", i, cpu_run); end
      cycle();
    end
    ld_valid = 0; #1;
    if (ld_ready) rdy++;
    total++; if (rdy != 3) begin bad++; $display("FAIL basic_ready_cycles got=%0d exp=3", rdy); end
    total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL basic_run got=%b exp=1", cpu_run); end
    for (int i = 0; i < 3; i++) begin
      cpu_addr = AW'(i); #1;
      total++; if (cpu_instr !== w[i]) begin bad++; $display("FAIL basic_fetch a=%0d got=%h exp=%h", i, cpu_instr, w[i]); end
    end
    total++; if (ld_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", ld_count); end
    total++; if (ld_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", ld_err); end
    cpu_halt = 1; cycle(); cpu_halt = 0;
  endtask

  task automatic test_gapped();
    bit pat [4];
    logic [31:0] d0, d1;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    d0 = $urandom; d1 = $urandom;
    ld_start = 1; ld_len = 2; cycle(); ld_start = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = pat[i]; ld_data = (i == 0) ? d0 : (pat[i] ? d1 : 32'hDEAD_BEEF);
      #1;
      total++; if (cpu_run !== 1'b0 || ld_ready !== 1'b1) begin
        bad++; $display("FAIL gap_loading i=%0d run=%b rdy=%b exp run=0 rdy=1", i, cpu_run, ld_ready); end
      cycle();
    end
    ld_valid = 0; #1;
    total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL gap_run got=%b exp=1", cpu_run); end
    cpu_addr = 0; #1;
    total++; if (cpu_instr !== d0) begin bad++; $display("FAIL gap_a0 got=%h exp=%h", cpu_instr, d0); end
    cpu_addr = 1; #1;
    total++; if (cpu_instr !== d1) begin bad++; $display("FAIL gap_a1 got=%h exp=%h", cpu_instr, d1); end
    total++; if (ld_count !== 16'd2) begin bad++; $display("FAIL gap_count got=%0d exp=2", ld_count); end
    cpu_halt = 1; cycle(); cpu_halt = 0;
  endtask

  task automatic test_clamp();
    int acc = 0;
    ld_start = 1; ld_len = 40; cycle(); ld_start = 0;
    for (int i = 0; i < 60 && ld_ready; i++) begin
      ld_valid = 1; ld_data = $urandom; acc++;
      cycle();
    end
    ld_valid = 0; #1;
    total++; if (acc != DEPTH) begin bad++; $display("FAIL clamp_accepted got=%0d exp=%0d", acc, DEPTH); end
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL clamp_err got=%b exp=1", ld_err); end
    total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL clamp_run got=%b exp=1", cpu_run); end
    total++; if (ld_count !== 16'(DEPTH)) begin bad++; $display("FAIL clamp_count got=%0d exp=%0d", ld_count, DEPTH); end
    cpu_addr = 35; #1;
    total++; if (cpu_instr !== 32'h0) begin bad++; $display("FAIL clamp_oob got=%h exp=0", cpu_instr); end
    for (int i = 0; i < 6; i++) begin
      cpu_addr = AW'($urandom_range(0, DEPTH-1)); #1;
      total++; if (cpu_instr !== exp_instr()) begin
        bad++; $display("FAIL clamp_fetch a=%0d got=%h exp=%h", cpu_addr, cpu_instr, exp_instr()); end
    end
  endtask

  task automatic test_halt_start();
    cpu_addr = 0;
    cpu_halt = 1; ld_start = 1; ld_len = 5; cycle(); cpu_halt = 0; ld_start = 0;
    total++; if (cpu_run !== 1'b0 || cpu_instr !== 32'h0) begin
      bad++; $display("FAIL hs_idle run=%b instr=%h exp run=0 instr=0", cpu_run, cpu_instr); end
    cycle();
    total++; if (ld_ready !== 1'b0 || ld_count !== 16'(DEPTH)) begin
      bad++; $display("FAIL hs_no_load rdy=%b cnt=%0d exp rdy=0 cnt=%0d", ld_ready, ld_count, DEPTH); end
    ld_start = 1; ld_len = 1; cycle(); ld_start = 0;
    total++; if (ld_err !== 1'b0 || ld_ready !== 1'b1) begin
      bad++; $display("FAIL hs_restart err=%b rdy=%b exp err=0 rdy=1", ld_err, ld_ready); end
    ld_valid = 1; ld_data = 32'h6000_0001; cycle(); ld_valid = 0; #1;
    total++; if (cpu_run !== 1'b1 || cpu_instr !== 32'h6000_0001) begin
      bad++; $display("FAIL hs_word run=%b instr=%h exp run=1 instr=60000001", cpu_run, cpu_instr); end
    cpu_halt = 1; cycle(); cpu_halt = 0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] d [2];
    d[0] = $urandom; d[1] = $urandom;
    ld_start = 1; ld_len = 5; cycle(); ld_start = 0;
    for (int i = 0; i < 2; i++) begin ld_valid = 1; ld_data = d[i]; cycle(); end
    ld_valid = 0; rst = 1; cycle(); rst = 0; #1;
    total++; if (ld_ready !== 1'b0 || ld_count !== '0 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL rst_mid rdy=%b cnt=%0d run=%b exp 0/0/0", ld_ready, ld_count, cpu_run); end
    ld_start = 1; ld_len = 0; cycle(); ld_start = 0;
    total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL rst_len0_run got=%b exp=1", cpu_run); end
    for (int i = 0; i < 2; i++) begin
      cpu_addr = AW'(i); #1;
      total++; if (cpu_instr !== d[i]) begin bad++; $display("FAIL rst_keep a=%0d got=%h exp=%h", i, cpu_instr, d[i]); end
    end
    cpu_halt = 1; cycle(); cpu_halt = 0;
  endtask

  task automatic test_wrong_state();
    logic [31:0] keep;
    keep = m_mem[0];
    ld_valid = 1; ld_data = ~keep; cycle(); cycle(); ld_valid = 0;
    total++; if (ld_ready !== 1'b0 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL ws_idle_valid rdy=%b run=%b exp 0/0", ld_ready, cpu_run); end
    ld_start = 1; ld_len = 0; cycle(); ld_start = 0;
    ld_valid = 1; ld_data = ~keep; cycle(); ld_valid = 0;
    cpu_addr = 0; #1;
    total++; if (cpu_run !== 1'b1 || cpu_instr !== keep) begin
      bad++; $display("FAIL ws_run_valid run=%b instr=%h exp run=1 instr=%h", cpu_run, cpu_instr, keep); end
    cpu_halt = 1; cycle(); cpu_halt = 0;
    ld_start = 1; ld_len = 2; cycle(); ld_start = 0;
    cpu_halt = 1; ld_start = 1; ld_len = 7; cycle(); cpu_halt = 0; ld_start = 0;
    total++; if (ld_ready !== 1'b1 || ld_count !== '0 || cpu_run !== 1'b0) begin
      bad++; $display("FAIL ws_load_halt rdy=%b cnt=%0d run=%b exp 1/0/0", ld_ready, ld_count, cpu_run); end
    for (int i = 0; i < 2; i++) begin ld_valid = 1; ld_data = $urandom; cycle(); end
    ld_valid = 0; #1;
    total++; if (cpu_run !== 1'b1 || ld_count !== 16'd2) begin
      bad++; $display("FAIL ws_load_done run=%b cnt=%0d exp 1/2", cpu_run, ld_count); end
    cpu_halt = 1; cycle(); cpu_halt = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      ld_start = ($urandom_range(0, 99) < 12);
      ld_len   = (AW+1)'($urandom_range(0, 40));
      ld_valid = ($urandom_range(0, 99) < 60);
      ld_data  = $urandom;
      cpu_halt = ($urandom_range(0, 99) < 6);
      cpu_addr = AW'($urandom_range(0, 40));
      #1;
      total++;
      if (cpu_run !== (m_mode == 2) || ld_ready !== (m_mode == 1) || ld_err !== m_err ||
          ld_count !== 16'(m_ptr) || (exp_known() && cpu_instr !== exp_instr())) begin
        bad++;
        $display("FAIL rand c=%0d run=%b rdy=%b err=%b cnt=%0d instr=%h exp run=%b rdy=%b err=%b cnt=%0d instr=%h",
                 c, cpu_run, ld_ready, ld_err, ld_count, cpu_instr,
                 m_mode == 2, m_mode == 1, m_err, m_ptr, exp_instr());
      end
      cycle();
    end
    rst = 0; ld_start = 0; ld_valid = 0; cpu_halt = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 'x; m_wr[i] = 0; end
    test_reset();
    test_basic();
    test_gapped();
    test_clamp();
    test_halt_start();
    test_rst_mid();
    test_wrong_state();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
